// File: rtl/param_reg_file.sv
// Parameterised multi-read-port register file with a post-reset clear sequence.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module param_reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     resetIn,
    input  logic [NUM_RD*ADDR_W-1:0] readAddr,
    input  logic                     writeEnable,
    input  logic [ADDR_W-1:0]        writeAddr,
    input  logic [DATA_W-1:0]        writeData,
    output logic [NUM_RD*DATA_W-1:0] outData,
    output logic                     busy,
    output logic                     resetOut
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = '1;
    localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);

    typedef enum logic {StClear, StReady} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic                busy_q;
    logic                reset_out_q;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                clr_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   rd_addr [NUM_RD];
    logic [DATA_W-1:0]   rd_data [NUM_RD];

    // Controller: the pointer holds at the last entry once the sweep finishes.
    always_ff @(posedge clk) begin
        if (resetIn) begin
            state_q     <= StClear;
            clr_ptr_q   <= '0;
            busy_q      <= 1'b1;
            reset_out_q <= 1'b1;
        end else begin
            reset_out_q <= 1'b0;
            if (state_q == StClear) begin
                if (clr_ptr_q == LastAddr) begin
                    state_q <= StReady;
                    busy_q  <= 1'b0;
                end else begin
                    clr_ptr_q <= clr_ptr_q + PtrOne;
                end
            end
        end
    end

    always_comb begin
        clr_en = 1'b0;
        wr_en  = 1'b0;
        if (!resetIn) begin
            clr_en = (state_q == StClear);
            wr_en  = (state_q == StReady) && writeEnable && (writeAddr != '0);
        end
    end

    // Storage is never touched on a reset edge; the clear sweep zeroes it afterwards.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            regs_q[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            regs_q[writeAddr] <= writeData;
        end
    end

    // Reset is folded in so reads go to zero in the very cycle reset is raised.
    assign busy     = busy_q | resetIn;
    assign resetOut = reset_out_q;

    always_comb begin
        outData = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr[p] = readAddr[p*ADDR_W +: ADDR_W];
            rd_data[p] = regs_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (rd_addr[p] == writeAddr)) begin
                rd_data[p] = writeData;
            end
`endif
            if (busy || (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end
            outData[p*DATA_W +: DATA_W] = rd_data[p];
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: a default 2-port instance and a 4-port,
// 8-entry instance, with expected read data queued as each read is driven.
module tb_param_reg_file;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: DATA_W=32, ADDR_W=5, NUM_RD=2
    logic        rst;
    logic [9:0]  ra;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [63:0] od;
    logic        bsy;
    logic        rsto;

    // Small instance: DATA_W=32, ADDR_W=3, NUM_RD=4
    logic         rst4;
    logic [11:0]  ra4;
    logic         we4;
    logic [2:0]   wa4;
    logic [31:0]  wd4;
    logic [127:0] od4;
    logic         bsy4;
    logic         rsto4;

    param_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk(clk), .resetIn(rst), .readAddr(ra), .writeEnable(we), .writeAddr(wa),
        .writeData(wd), .outData(od), .busy(bsy), .resetOut(rsto)
    );

    param_reg_file #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) dut4 (
        .clk(clk), .resetIn(rst4), .readAddr(ra4), .writeEnable(we4), .writeAddr(wa4),
        .writeData(wd4), .outData(od4), .busy(bsy4), .resetOut(rsto4)
    );

    typedef struct {
        string       tag;
        int          inst;
        int          port;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          n_total = 0;
    int          n_bad   = 0;

    logic [31:0] mdl [32];
    bit          mdl_busy = 1'b1;
    int          mdl_ptr  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] addr);
        if (rst || mdl_busy || addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == addr) return wd;
`endif
        return mdl[addr];
    endfunction

    function automatic logic [31:0] dut_rd(input int inst, input int port);
        if (inst == 0) return od[port*32 +: 32];
        return od4[port*32 +: 32];
    endfunction

    task automatic push(input string tag, input int inst, input int port, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag; e.inst = inst; e.port = port; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("%s.p%0d", e.tag, e.port), 64'(dut_rd(e.inst, e.port)), 64'(e.exp));
        end
    endtask

    // One clock on the default instance: drive, check combinational reads, clock, update model.
    task automatic cycle(input string tag, input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] r0, input logic [4:0] r1);
        rst = r; we = w; wa = a; wd = d; ra = {r1, r0};
        #1;
        push(tag, 0, 0, exp_rd(r0));
        push(tag, 0, 1, exp_rd(r1));
        drain();
        check({tag, ".busy"}, 64'(bsy), 64'(r | mdl_busy));
        @(posedge clk);
        if (r) begin
            mdl_busy = 1'b1;
            mdl_ptr  = 0;
        end else if (mdl_busy) begin
            mdl[mdl_ptr] = 32'h0;
            if (mdl_ptr == 31) mdl_busy = 1'b0;
            else mdl_ptr++;
        end else if (w && a != 5'd0) begin
            mdl[a] = d;
        end
        #1;
        check({tag, ".rsto"}, 64'(rsto), 64'(r));
    endtask

    // Release reset and count edges until busy falls, bounded.
    task automatic run_clear(input string tag, input int exp_n, input logic w,
                             input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        while (n < 64) begin
            cycle(tag, 1'b0, w, a, d, a, 5'd9);
            n++;
            if (bsy == 1'b0) break;
        end
        check({tag, ".edges"}, 64'(n), 64'(exp_n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
        rst4 = 1'b1; we4 = 1'b0; wa4 = '0; wd4 = '0; ra4 = '0;
        #2;

        cycle("reset", 1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        // Writes to r3 throughout the sweep must be dropped.
        run_clear("clr", 32, 1'b1, 5'd3, 32'h55);
        cycle("r3_after", 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        check("r3_zero", 64'(od[31:0]), 64'h0);

        cycle("wr_r5",   1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        cycle("rd_r5",   1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check("r5_val",  64'(od[63:32]), 64'hDEADBEEF);
        cycle("wr_r0",   1'b0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        cycle("rd_r0",   1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        cycle("wr_r7",   1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        cycle("rd_r7",   1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        check("r7_val",  64'(od[31:0]), 64'hA5A5A5A5);
        cycle("wr_r9",   1'b0, 1'b1, 5'd9, 32'h77, 5'd0, 5'd0);
        cycle("rd_r9",   1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7);

        // Reset from READY, then a second reset at clear-step 10.
        cycle("rst_rdy", 1'b1, 1'b1, 5'd9, 32'h99, 5'd9, 5'd7);
        for (int i = 0; i < 10; i++) cycle("part", 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
        cycle("rst_mid", 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
        run_clear("reclr", 32, 1'b0, 5'd0, 32'h0);
        cycle("rd_post", 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
        check("r9_zero", 64'(od[31:0]), 64'h0);
        cycle("wr_r31",  1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1);
        cycle("rd_r31",  1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);

        // Four-port, eight-entry instance.
        @(posedge clk); #1;
        check("d4.rsto_hi", 64'(rsto4), 64'h1);
        rst4 = 1'b0;
        n = 0;
        while (n < 32) begin
            @(posedge clk); #1;
            n++;
            if (bsy4 == 1'b0) break;
        end
        check("d4.edges", 64'(n), 64'd8);
        check("d4.rsto_lo", 64'(rsto4), 64'h0);
        for (int i = 1; i < 8; i++) begin
            we4 = 1'b1; wa4 = 3'(i); wd4 = 32'h100 + 32'(i) * 32'h11;
            @(posedge clk); #1;
        end
        we4 = 1'b0;
        ra4 = {3'd7, 3'd4, 3'd6, 3'd1};
        push("d4.a", 1, 0, 32'h111); push("d4.a", 1, 1, 32'h166);
        push("d4.a", 1, 2, 32'h144); push("d4.a", 1, 3, 32'h177);
        #1; drain();
        ra4 = {3'd5, 3'd2, 3'd2, 3'd0};
        push("d4.b", 1, 0, 32'h0);   push("d4.b", 1, 1, 32'h122);
        push("d4.b", 1, 2, 32'h122); push("d4.b", 1, 3, 32'h155);
        #1; drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bits per register entry.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, legal 1..4, meaning number of independent read ports.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port resetIn  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port readAddr  input  NUM_RD*ADDR_W  packed read addresses; port p at bits [p*ADDR_W +: ADDR_W].
REQ-007 SHALL have port writeEnable  input  1  write request for the current cycle.
REQ-008 SHALL have port writeAddr  input  ADDR_W  write address.
REQ-009 SHALL have port writeData  input  DATA_W  write data.
REQ-010 SHALL have port outData  output  NUM_RD*DATA_W  packed read data; port p at bits [p*DATA_W +: DATA_W].
REQ-011 SHALL have port busy  output  1  high while reset or clear sequence is in progress.
REQ-012 SHALL have port resetOut  output  1  registered copy of resetIn for downstream stages.

Function
REQ-013 SHALL implement a two-state controller: CLEAR and READY.
REQ-014 CLEAR: clrPtr (ADDR_W bits) writes regs[clrPtr] = 0 at each edge with resetIn=0, then increments.
REQ-015 CLEAR -> READY at the edge that clears entry DEPTH-1; busy goes low on that same edge.
REQ-016 With resetIn held low from edge E onward, busy SHALL be low after edge E+DEPTH-1 (32 edges in total for DEPTH=32).
REQ-017 READY: writeEnable=1 and writeAddr!=0 SHALL write writeData into regs[writeAddr] at the rising edge.
REQ-018 Writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0 at all times.
REQ-019 Writes while busy=1 SHALL be discarded; no error indication.
REQ-020 Reads SHALL be combinational; each port returns regs[readAddr_p] with zero-cycle latency.
REQ-021 While busy=1, every outData port SHALL read 0.
REQ-022 Multiple read ports addressing the same entry SHALL return identical data.
REQ-023 clrPtr SHALL NOT wrap: when CLEAR ends, clrPtr holds until the next reset.

Reset
REQ-024 At an edge with resetIn=1: state=CLEAR, clrPtr=0, busy=1, resetOut=1; register contents are not modified on that edge.
REQ-025 At an edge with resetIn=0: resetOut=0.
REQ-026 Reset asserted mid-CLEAR SHALL restart the sequence from entry 0.
REQ-027 Reset asserted in READY SHALL re-enter CLEAR; previously written data is zeroed by the new sequence.
REQ-028 outData SHALL read 0 in the same cycle resetIn is high (busy is already high).

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: in READY, a read port whose address equals writeAddr (non-zero) while writeEnable=1 SHALL return writeData in that same cycle.
REQ-030 REGFILE_BYPASS_EN undefined: that read SHALL return the old stored value; the new value is visible from the cycle after the edge.
REQ-031 The macro SHALL affect only read-path forwarding; write timing and the clear sequence are identical in both builds.

Verification
REQ-032 Reset one cycle, then count edges with resetIn=0 -> busy=1 for 31 edges; busy=0 after the 32nd edge (DEPTH=32); all reads return 0 while busy.
REQ-033 READY: write 0xDEADBEEF to r5, then read r5 on both ports -> both return 0xDEADBEEF; write 0x1234 to r0 -> read r0 returns 0.
REQ-034 Same-cycle write r7=0xA5A5A5A5 and read r7 -> with macro: 0xA5A5A5A5 that cycle; without macro: old value (0) that cycle, 0xA5A5A5A5 the next cycle.
REQ-035 Write r3=0x55 during busy -> after busy falls, r3 reads 0.
REQ-036 Write r9=0x77, then reset for one cycle at clear-step 10, then release -> busy stays high a further 32 edges; r9 reads 0 afterwards; resetOut mirrors resetIn one edge later.
REQ-037 NUM_RD=4, ADDR_W=3: write distinct values to r1..r7, read four distinct addresses -> each port returns its own entry; busy clears after 8 edges.
